// File: rtl/modport_dut_pkg.sv
// Shared definitions for the APB3 register completer.
//   state_e          : APB phase tracked by the completer FSM
//   ADDR_MAX_W       : widest PADDR accepted by the error decoder
//   ID_OFFSET        : word index of the read-only ID register
//   DEFAULT_ID_VALUE : default contents of the ID register
//   is_err()         : transfer error decode (misaligned, out of range,
//                      write to the ID word)
package modport_dut_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam int unsigned ADDR_MAX_W       = 64;
  localparam int unsigned ID_OFFSET        = 0;
  localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA0B1_0001;

  // addr is the zero-extended byte address; num_regs counts the ID word.
  function automatic logic is_err(input logic [ADDR_MAX_W-1:0] addr,
                                  input logic                  write,
                                  input int unsigned           num_regs);
    logic [ADDR_MAX_W-3:0] idx;
    idx = addr[ADDR_MAX_W-1:2];
    return (addr[1:0] != 2'b00) ||
           (idx >= (ADDR_MAX_W-2)'(num_regs)) ||
           (write && (idx == (ADDR_MAX_W-2)'(ID_OFFSET)));
  endfunction

endpackage

// File: rtl/modport_dut_regfile.sv
// Word-addressed register storage for the APB completer.
//   PCLK  : clock
//   rst   : synchronous active-high reset, clears every word
//   we    : write enable (one full word)
//   widx  : write word index
//   wdata : write data
//   ridx  : combinational read word index
//   rdata : combinational read data
module modport_dut_regfile #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 4
) (
  input  logic                  PCLK,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  always_ff @(posedge PCLK) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/modport_dut.sv
// APB3 completer: one read-only ID word at offset 0 followed by
// NUM_REGS-1 read/write scratch words, with programmable wait states.
//   PCLK    : clock (posedge)
//   rst     : synchronous active-high reset
//   PSEL    : completer select
//   PENABLE : access phase
//   PADDR   : byte address
//   PWRITE  : 1 = write, 0 = read
//   PWDATA  : write data
//   PRDATA  : read data, zero unless a good read completes this cycle
//   PREADY  : transfer completes this cycle
//   PSLVERR : error on the completing transfer
module modport_dut
  import modport_dut_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_CYCLES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(DEFAULT_ID_VALUE)
) (
  input  logic                  PCLK,
  input  logic                  rst,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int         IDX_W  = $clog2(NUM_REGS);
  localparam logic [3:0] WAIT_Q = 4'(WAIT_CYCLES);

  state_e                state_p0;
  state_e                cur_state;
  logic                  done_p0;
  logic                  rst_p0;
  logic [3:0]            wcnt_p0;

  logic [ADDR_MAX_W-1:0] addr_ext;
  logic [IDX_W-1:0]      idx;
  logic                  err;
  logic                  ready;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rdata;

  assign addr_ext = ADDR_MAX_W'(PADDR);
  assign idx      = PADDR[IDX_W+1:2];
  assign err      = is_err(addr_ext, PWRITE, NUM_REGS);

  // Phase of the current bus cycle. SETUP always leads into ACCESS, and an
  // unfinished ACCESS stays there. Otherwise PENABLE high means ACCESS: that
  // covers both entering from IDLE without a SETUP and PENABLE held after a
  // completed transfer, which simply repeats the transfer from wait count 0.
  always_comb begin
    cur_state = IDLE;
    if (PSEL) begin
      if ((state_p0 == SETUP) || ((state_p0 == ACCESS) && !done_p0) || PENABLE) begin
        cur_state = ACCESS;
      end else begin
        cur_state = SETUP;
      end
    end
  end

  // Held low through the reset cycle and the cycle after it so a manager
  // still driving an access phase across reset sees no completion.
  assign ready = PSEL && PENABLE && (wcnt_p0 == WAIT_Q) && !rst && !rst_p0;
  assign wr_en = ready && PWRITE && !err;

  // ---- stage p0: FSM, wait counter, reset delay ----
  always_ff @(posedge PCLK) begin
    rst_p0 <= rst;
    if (rst) begin
      state_p0 <= IDLE;
      done_p0  <= 1'b0;
      wcnt_p0  <= 4'd0;
    end else begin
      state_p0 <= cur_state;
      done_p0  <= ready;
      if ((cur_state == ACCESS) && !ready && !rst_p0) begin
        wcnt_p0 <= wcnt_p0 + 4'd1;
      end else begin
        wcnt_p0 <= 4'd0;
      end
    end
  end

  modport_dut_regfile #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .PCLK  (PCLK),
    .rst   (rst),
    .we    (wr_en),
    .widx  (idx),
    .wdata (PWDATA),
    .ridx  (idx),
    .rdata (rdata)
  );

  assign PREADY  = ready;
  assign PSLVERR = ready && err;

  always_comb begin
    PRDATA = '0;
    if (ready && !err && !PWRITE) begin
      PRDATA = (idx == IDX_W'(ID_OFFSET)) ? ID_VALUE : rdata;
    end
  end

endmodule

// File: tb/tb_modport_dut.sv
module tb_modport_dut;

  localparam logic [31:0] ID = 32'hA0B1_0001;
  localparam int W0 = 0;
  localparam int W1 = 3;

  typedef struct {
    string       tag;
    bit          rd;
    logic [31:0] data;
    logic        err;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata [2];
  logic [1:0]  pready;
  logic [1:0]  pslverr;

  logic [31:0] mdl [2][16];
  exp_t        sb[$];
  int          ncmp = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  modport_dut #(.WAIT_CYCLES(W0)) dut0 (
    .PCLK(clk), .rst(rst), .PSEL(psel[0]), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0])
  );

  modport_dut #(.WAIT_CYCLES(W1)) dut1 (
    .PCLK(clk), .rst(rst), .PSEL(psel[1]), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        mdl[d][i] = 32'h0;
  endtask

  // Starts at posedge+1 and returns at posedge+1 with the bus idle, so a
  // following call is a back-to-back transfer.
  task automatic xfer(input int d, input string name, input logic [31:0] a,
                      input bit w, input logic [31:0] wd);
    exp_t e;
    exp_t g;
    int   idx;
    int   cyc;
    logic er;
    idx     = int'(a >> 2);
    er      = (a[1:0] != 2'b00) || (idx >= 16) || (w && idx == 0);
    e.tag   = $sformatf("d%0d_%s", d, name);
    e.rd    = !w;
    e.err   = er;
    e.waits = ((d == 0) ? W0 : W1) + 1;
    e.data  = 32'h0;
    if (!er && !w) e.data = (idx == 0) ? ID : mdl[d][idx];
    sb.push_back(e);

    psel[d] = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pready[d] || cyc >= 32) break;
      @(posedge clk); #1;
    end
    g = sb.pop_front();
    chk({g.tag, "_waits"}, 32'(cyc), 32'(g.waits));
    chk({g.tag, "_err"}, {31'h0, pslverr[d]}, {31'h0, g.err});
    if (g.rd) chk({g.tag, "_data"}, prdata[d], g.data);
    if (w && !er && pready[d]) mdl[d][idx] = wd;
    @(posedge clk); #1;
    psel = 2'b00; penable = 1'b0;
  endtask

  task automatic gap();
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_write(input int d);
    psel[d] = 1'b1; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    penable = 1'b1;
    rst     = 1'b1;
    @(negedge clk);
    chk($sformatf("d%0d_rst_cycle_pready", d), {31'h0, pready[d]}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    chk($sformatf("d%0d_post_rst_pready", d), {31'h0, pready[d]}, 32'h0);
    chk($sformatf("d%0d_post_rst_prdata", d), prdata[d], 32'h0);
    @(posedge clk); #1;
    psel = 2'b00; penable = 1'b0;
    gap();
    xfer(d, "rd_0c_after_rst", 32'h0C, 1'b0, 32'h0);
    gap();
    xfer(d, "rd_04_after_rst", 32'h04, 1'b0, 32'h0);
  endtask

  task automatic run_suite(input int d);
    logic [31:0] v;
    int          k;
    xfer(d, "rd_04_init", 32'h04, 1'b0, 32'h0);
    gap();
    xfer(d, "wr_04", 32'h04, 1'b1, 32'hDEAD_BEEF);
    gap();
    xfer(d, "rd_04", 32'h04, 1'b0, 32'h0);
    gap();
    xfer(d, "rd_id", 32'h00, 1'b0, 32'h0);
    gap();
    xfer(d, "wr_id", 32'h00, 1'b1, 32'h1);
    gap();
    xfer(d, "rd_id_again", 32'h00, 1'b0, 32'h0);
    gap();
    xfer(d, "rd_40_oob", 32'h40, 1'b0, 32'h0);
    gap();
    xfer(d, "wr_06_misal", 32'h06, 1'b1, 32'h1234_5678);
    gap();
    xfer(d, "rd_04_post_misal", 32'h04, 1'b0, 32'h0);
    gap();
    xfer(d, "rd_06_misal", 32'h06, 1'b0, 32'h0);
    gap();
    xfer(d, "rd_3c_last", 32'h3C, 1'b0, 32'h0);
    gap();
    // back-to-back: no idle cycle between the two transfers
    xfer(d, "wr_08_b2b", 32'h08, 1'b1, 32'h5);
    xfer(d, "rd_08_b2b", 32'h08, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(15, 1);
      v = $urandom;
      xfer(d, $sformatf("wr_rand%0d", i), 32'(k << 2), 1'b1, v);
      xfer(d, $sformatf("rd_rand%0d", i), 32'(k << 2), 1'b0, 32'h0);
    end
    gap();
    reset_mid_write(d);
    gap();
  endtask

  initial begin
    rst = 1'b1; psel = 2'b00; penable = 1'b0; paddr = 32'h0; pwrite = 1'b0; pwdata = 32'h0;
    clear_model();
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_reset_pready", d), {31'h0, pready[d]}, 32'h0);
      chk($sformatf("d%0d_reset_pslverr", d), {31'h0, pslverr[d]}, 32'h0);
      chk($sformatf("d%0d_reset_prdata", d), prdata[d], 32'h0);
    end
    @(posedge clk); #1;
    run_suite(0);
    run_suite(1);
    chk("sb_left", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
